// File: rtl/seg7_scan_driver_if.sv
// Display-side bus of the seven-segment scan driver: value/control in, anode/segment drive out.
interface seg7_scan_driver_if;
  logic [15:0] data_in;
  logic        en;
  logic        lz_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output data_in, en, lz_blank, input an, seg, dp);
  modport slave  (input data_in, en, lz_blank, output an, seg, dp);
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit hex scan driver for a common-anode multiplexed seven-segment display,
// with a per-slot dark guard interval and frame-boundary capture of the shown value.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic              clk,
  input  logic              reset,
  seg7_scan_driver_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       nibble;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every digit to its left are zero; digit0 always shows.
  function automatic logic lead_zero(input logic [1:0] dig, input logic [15:0] val);
    logic z;
    case (dig)
      2'd3:    z = (val[15:12] == 4'h0);
      2'd2:    z = (val[15:8]  == 8'h00);
      2'd1:    z = (val[15:4]  == 12'h000);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  assign nibble = shadow_q[4*digit_q +: 4];

  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    digit_d  = digit_q;
    shadow_d = shadow_q;
    an_d     = 4'b1111;
    seg_d    = 7'b1111111;

    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
      if (digit_q == 2'd3) shadow_d = bus.data_in;
    end

    if (bus.en && (cnt_q >= GUARD_C) && !(bus.lz_blank && lead_zero(digit_q, shadow_q))) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = hex7(nibble);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      digit_q  <= 2'd0;
      shadow_q <= 16'h0000;
      an_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
    end else begin
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised and directed bench for seg7_scan_driver against a position-based display model.
module tb_seg7_scan_driver;
  localparam int DIV   = 8;
  localparam int GRD   = 2;
  localparam int FRAME = 4 * DIV;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic clk = 1'b0;
  logic reset;
  seg7_scan_driver_if bus();

  seg7_scan_driver #(.REFRESH_DIV(DIV), .GUARD(GRD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int p;               // clock edges since reset release
  logic [15:0] sh;     // value the model believes is on display this frame

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (pos %0d)", tag, obs, exp, p);
    end
  endtask

  // Expected {an, seg} after the edge that ends position pos.
  function automatic logic [10:0] model(int pos, logic [15:0] v, logic e, logic lz);
    int c, d;
    logic dark;
    c = pos % DIV;
    d = (pos / DIV) % 4;
    dark = !e || (c < GRD) || (lz && d > 0 && (v >> (4 * d)) == 16'h0);
    if (dark) return {4'b1111, 7'b1111111};
    return {~(4'b0001 << d), HEX[v[4*d +: 4]]};
  endfunction

  task automatic step();
    logic [10:0] exp;
    logic        cap;
    logic [15:0] nd;
    exp = model(p, sh, bus.en, bus.lz_blank);
    cap = (p % FRAME == FRAME - 1);
    nd  = bus.data_in;
    @(posedge clk);
    @(negedge clk);
    chk("an", {28'd0, bus.an}, {28'd0, exp[10:7]});
    chk("seg", {25'd0, bus.seg}, {25'd0, exp[6:0]});
    chk("dp", {31'd0, bus.dp}, 32'd1);
    chk("onehot", {31'd0, ($countones(~bus.an) <= 1)}, 32'd1);
    if (cap) sh = nd;
    p++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to(input int pos_in_frame);
    int guard_cnt = 0;
    while ((p % FRAME) != pos_in_frame && guard_cnt < 2 * FRAME) begin
      step();
      guard_cnt++;
    end
  endtask

  initial begin
    p = 0;
    sh = 16'h0;
    bus.data_in  = 16'h0000;
    bus.en       = 1'b1;
    bus.lz_blank = 1'b0;
    reset        = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_an", {28'd0, bus.an}, 32'hF);
    chk("rst_seg", {25'd0, bus.seg}, 32'h7F);
    chk("rst_dp", {31'd0, bus.dp}, 32'd1);
    reset = 1'b0;

    // Full-value display over two frames.
    bus.data_in = 16'h1A3F;
    run(2 * FRAME);

    // Mid-frame change must not tear.
    bus.data_in = 16'h1234;
    run_to(0);
    run(FRAME + DIV + 3);
    bus.data_in = 16'hBEEF;
    run(2 * FRAME);

    // Leading-zero blanking.
    bus.lz_blank = 1'b1;
    bus.data_in  = 16'h00A0;
    run_to(0);
    run(2 * FRAME);
    bus.data_in = 16'h0000;
    run(2 * FRAME);
    bus.lz_blank = 1'b0;

    // Enable pulse mid-slot.
    bus.data_in = 16'h5A5A;
    run_to(DIV + 3);
    bus.en = 1'b0;
    run(5);
    bus.en = 1'b1;
    run(FRAME);

    // Asynchronous reset at cnt=5, digit=2.
    run_to(2 * DIV + 5);
    reset = 1'b1;
    #1;
    chk("arst_an", {28'd0, bus.an}, 32'hF);
    chk("arst_seg", {25'd0, bus.seg}, 32'h7F);
    @(posedge clk);
    @(negedge clk);
    chk("arst_hold_an", {28'd0, bus.an}, 32'hF);
    reset = 1'b0;
    p = 0;
    sh = 16'h0;
    run(2 * FRAME);

    // Randomised quasi-static controls and data.
    repeat (900) begin
      if ($urandom_range(0, 23) == 0) bus.data_in = 16'($urandom);
      if ($urandom_range(0, 63) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 63) == 0) bus.lz_blank = ~bus.lz_blank;
      if ($urandom_range(0, 40) == 0) bus.data_in = 16'($urandom_range(0, 255));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Consumes the CPU's 16-bit `out` result bus and shows it as four hexadecimal digits on a common-anode multiplexed seven-segment display. It sits downstream of the `mips` top and is instantiated next to it in the board-level wrapper. It time-multiplexes the digits with a programmable refresh prescaler and an anti-ghosting guard interval. The displayed value is captured only at frame boundaries, so a value never tears across digits mid-frame.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot; legal range 4 to 2^20.
GUARD, 16, cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
data_in  input  16  value to display; connects to mips `out`; nibble 3 is the leftmost digit
en  input  1  display enable; when low, anodes are forced off and counters keep running
lz_blank  input  1  when high, suppresses leading zero digits
an  output  4  anode selects, active-low; an[3] is the leftmost digit
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low; constant 1 (off) outside reset

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
  - On reset: cnt=0, digit=0, shadow=16'h0000, an=4'b1111, seg=7'b1111111, dp=1.
- Prescaler cnt:
  - Counts 0..REFRESH_DIV-1 every clock.
  - At REFRESH_DIV-1 it wraps to 0 and digit advances 0→1→2→3→0.
- Frame capture: when cnt==REFRESH_DIV-1 and digit==3, shadow <= data_in. No other update path exists.
  - data_in changes mid-frame are invisible until the next capture.
  - After reset, shadow stays 0 until the first 3→0 wrap (4*REFRESH_DIV cycles).
- Outputs are registered. an, seg and dp at edge N+1 are a function of (cnt, digit, shadow, en, lz_blank) sampled at edge N. This is a 1-cycle latency.
- Guard:
  - When cnt < GUARD, an=4'b1111 and seg=7'b1111111.
  - Otherwise an has only bit[digit] low.
- nibble = shadow[4*digit+3 : 4*digit].
- Hex encoding (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blank, applied when lz_blank=1:
  - digit3 is blanked if shadow[15:12]==0.
  - digit2 is blanked if shadow[15:8]==0.
  - digit1 is blanked if shadow[15:4]==0.
  - digit0 is never blanked, so 0x0000 shows a single "0".
  - A blanked digit drives an=4'b1111 and seg=7'b1111111 for its whole slot. Timing is unchanged.
- en=0: an=4'b1111 and seg=7'b1111111 one cycle later. cnt, digit and shadow capture continue unchanged. Re-enabling resumes at the current slot position.
- lz_blank and en are sampled every cycle, without synchronisation; they are treated as quasi-static.
- Reset mid-slot or mid-frame: all state returns immediately, asynchronously, to reset values. The outputs go dark in the same instant; no partial digit is left lit.
- Exactly one or zero anodes are low in any cycle. Two simultaneous active anodes is a failure.

Test Plan:
Test parameters: REFRESH_DIV=8, GUARD=2.
- Reset pulse, then hold reset low → an=1111, seg=1111111, dp=1 during reset. First lit digit: an=1110, seg=1000000 ("0") appears on the 3rd edge after release. Slot length is exactly 8 cycles, with 2 dark cycles at the start of each slot.
- data_in=16'h1A3F held for 2 frames → second frame scans an 1110/1101/1011/0111 with seg 0001110 (F), 0110000 (3), 0001000 (A), 1111001 (1).
- Change data_in from 16'h1234 to 16'hBEEF while digit=1 → remaining digits of the current frame still show 1234. BEEF appears from the next frame's digit0 (seg=0001110).
- lz_blank=1, data_in=16'h00A0 → digits 3 and 2 are dark for their whole slots (an=1111). Digit1 shows A and digit0 shows 0. With data_in=16'h0000, only digit0 lights, showing "0".
- Pulse en=0 for 5 cycles mid-slot → an=1111 during those cycles plus 1. Slot and frame timing are unchanged afterwards, measured against cnt.
- Assert reset for 1 cycle at cnt=5, digit=2 → an=1111 immediately and shadow=0. Scan restarts at digit0 with identical post-reset timing. A checker asserts at most one active anode on every cycle of every test.
